// File: rtl/regfile_bypass_sb.sv
// Parametrised multi-port register file with optional write-to-read bypass,
// optional hardwired zero register and a per-register busy scoreboard.
// Decode reads operands and reserves its destination; writeback writes data
// and clears the busy bit of the register it writes.
module regfile_bypass_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] SrcReg,
  output logic [NUM_RD*DATA_W-1:0] SrcData,
  output logic [NUM_RD-1:0]        SrcBusy,
  input  logic                     WriteReg,
  input  logic [ADDR_W-1:0]        DstReg,
  input  logic [DATA_W-1:0]        DstData,
  input  logic                     RsvEn,
  input  logic [ADDR_W-1:0]        RsvReg,
  output logic [NUM_REGS-1:0]      BusyVec
);

  // An address names real storage when it is in range and is not the
  // hardwired zero register (which has no storage and no busy bit).
  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    logic [31:0] a_ext;
    a_ext = {{(32-ADDR_W){1'b0}}, a};
    return (a_ext < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [NUM_REGS-1:0][DATA_W-1:0] mem_q;
  logic [NUM_REGS-1:0]             busy_q;
  logic [NUM_REGS-1:0]             busy_d;
  logic                            wr_ok;
  logic                            rsv_ok;
  logic [ADDR_W-1:0]               rd_addr;
  logic                            rd_hit;

  // Qualified write/reserve strobes; while reset is held both are discarded,
  // which also keeps the bypass path quiet so every read returns zero.
  always_comb begin
    wr_ok  = WriteReg && !rst && addr_valid(DstReg);
    rsv_ok = RsvEn    && !rst && addr_valid(RsvReg);
  end

  // Scoreboard next state: a reserve beats a writeback on the same register,
  // since the newly issued producer supersedes the one retiring.
  always_comb begin
    busy_d = busy_q;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (rsv_ok && (RsvReg == ADDR_W'(n))) begin
        busy_d[n] = 1'b1;
      end else if (wr_ok && (DstReg == ADDR_W'(n))) begin
        busy_d[n] = 1'b0;
      end
    end
  end

  // Register storage; invalid writes never touch it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (wr_ok) begin
      mem_q[DstReg] <= DstData;
    end
  end

  // Busy scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign BusyVec = busy_q;

  // Combinational read ports; a forwarded write counts as ready data.
  always_comb begin
    SrcData = '0;
    SrcBusy = '0;
    rd_addr = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr = SrcReg[i*ADDR_W +: ADDR_W];
      rd_hit  = (BYPASS != 0) && wr_ok && (DstReg == rd_addr);
      if (addr_valid(rd_addr)) begin
        SrcData[i*DATA_W +: DATA_W] = rd_hit ? DstData : mem_q[rd_addr];
        SrcBusy[i]                  = busy_q[rd_addr] && !rd_hit;
      end
    end
  end

endmodule
